layer_packer: RTL
=================

# layer_packer

Serial-to-parallel collector that sits between the output-layer neurons and the argmax unit. It accepts one neuron result per valid cycle, in index order, into an assembly buffer. When all `numInput` results are present, it presents the whole vector as one packed word with a single-cycle valid. It will not issue a new vector while the downstream argmax scan is still running, because a valid pulse mid-scan would restart that scan.

## Interface
- `numInput`, 10: elements per frame (≥2).
- `inputWidth`, 16: bits per element.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_data`  in  inputWidth  one neuron result.
- `i_valid`  in  1  `i_data` is valid this cycle.
- `i_sink_done`  in  1  downstream finished its scan; wired to the argmax `o_data_valid`.
- `o_data`  out  numInput*inputWidth  packed frame; element k at `[k*inputWidth +: inputWidth]`.
- `o_valid`  out  1  single-cycle pulse; `o_data` is valid this cycle.
- `o_ready`  out  1  high when an `i_valid` sample will be stored.
- `o_overflow`  out  1  single-cycle pulse when an `i_valid` sample is dropped.

## Operation
- States:
  - FILL: accepting samples.
  - PEND: frame complete, waiting for the sink.
- Index counter `idx`, width `$clog2(numInput)`. It starts at 0 and advances on each accepted sample.
  - A sample in FILL is written to slot `idx`.
- Frame completion is an accepted sample with `idx == numInput-1`. On completion:
  - `idx` wraps to 0.
  - If the sink is not busy, the vector (including the final sample) is copied to `o_data` and `o_valid` is asserted next cycle; state stays FILL.
  - If the sink is busy, state goes to PEND.
- `sink_busy` flag:
  - Set in the cycle `o_valid` is driven high.
  - Cleared when `i_sink_done` is sampled high.
  - If the clear and a completion happen in the same cycle, the sink counts as free and the frame is emitted with no PEND.
- PEND:
  - `o_ready=0`.
  - Any `i_valid` is dropped and `o_overflow` pulses the following cycle.
  - When `i_sink_done` is sampled high, the held vector is copied to `o_data`, `o_valid` pulses next cycle, and the state returns to FILL.
- Data is stored unmodified; no arithmetic. `o_data` holds its last value between pulses.
- `i_sink_done` seen while the sink is not busy is ignored.

## Timing
- Reset values: `o_data=0`, `o_valid=0`, `o_ready=1`, `o_overflow=0`, `idx=0`, `sink_busy=0`, assembly buffer=0, state FILL.
- Latency: completion with the sink idle → `o_valid` exactly 1 cycle later.
- Latency from PEND: `i_sink_done` → `o_valid` exactly 1 cycle later.
- Minimum frame spacing is `numInput` cycles. `o_valid` is never high on two consecutive cycles.
- `o_ready` is registered. It drops the cycle after a completion that enters PEND and rises the cycle after leaving PEND.
- Reset mid-frame discards the partial frame and any pending frame; `i_rst` has priority over all inputs.
- Back-to-back valid across a frame boundary is allowed: sample `numInput-1` of one frame and sample 0 of the next arrive on adjacent cycles.

## Configuration
- `LAYER_PACKER_SOF_EN` defined:
  - Adds input `i_sof` (1 bit) and output `o_sync_err` (1-bit pulse).
  - `i_valid & i_sof` in FILL stores the sample at slot 0 and sets `idx=1`.
  - If `idx` was not 0, `o_sync_err` pulses next cycle and the partial frame is discarded.
  - `i_sof` in PEND is dropped like any other sample.
- `LAYER_PACKER_SOF_EN` undefined: no `i_sof` or `o_sync_err` ports; framing relies only on counting.

## Structure
- Shared package `cnn_pkg`: state enum (FILL, PEND) and a `clog2`-based index-width helper, reused by the argmax unit.
- One natural sub-module, `index_counter`: modulo-`numInput` counter with enable, synchronous clear and load-to-1 (the load serves SOF resync).
- Assembly buffer, copy to `o_data`, busy flag and state live in the top.

## Test plan
- Reset, then 10 consecutive samples 0x0001..0x000A, sink idle → `o_valid` pulse 1 cycle after the 10th; `o_data[15:0]=0x0001`, `o_data[159:144]=0x000A`.
- Frame 2 fully sent before `i_sink_done` → `o_ready=0` after completion; 11th sample dropped with `o_overflow` pulse; `i_sink_done` → `o_valid` next cycle with frame 2 data.
- Completion in the same cycle as `i_sink_done` → no PEND; `o_valid` next cycle; `o_ready` stays 1.
- 4 samples, `i_rst` for 1 cycle, then 10 samples 0x0100..0x0109 → single `o_valid`; slot 0 is 0x0100, no stale data.
- Gapped input (valid every 3rd cycle) over 10 samples → one `o_valid`, correct packing, `o_overflow` never asserted.
- With `LAYER_PACKER_SOF_EN`: `i_sof` asserted on the 4th sample → `o_sync_err` pulse; that sample lands in slot 0; `o_valid` occurs after 9 more samples.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: types and helpers shared by the output-layer packer and the argmax unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_pkg;

  // Frame collector states: FILL accepts samples, PEND holds a finished frame
  // until the downstream scan completes.
  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } state_t;

  // Width of an index that counts 0..n-1 (never less than one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/index_counter.sv
// index_counter: modulo-N slot counter with enable, synchronous clear and load-to-1.
// Latency: o_idx updates one cycle after i_en/i_clr/i_load1 are sampled.
// Backpressure: none; caller gates i_en.
// Ports: i_clk clock; i_clr sync clear (highest priority); i_load1 forces 1
//        (frame resync); i_en advances and wraps at N-1; o_idx current value.
module index_counter
  import cnn_pkg::*;
#(
  parameter int N = 10,
  parameter int W = idx_width(N)
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_load1,
  output logic [W-1:0] o_idx
);

  logic [W-1:0] idx_q;
  logic [W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (i_clr) begin
      idx_d = '0;
    end else if (i_load1) begin
      idx_d = W'(1);
    end else if (i_en) begin
      idx_d = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    idx_q <= idx_d;
  end

  assign o_idx = idx_q;

endmodule

// File: rtl/layer_packer.sv
// layer_packer: collects numInput neuron results into one packed frame for argmax.
// Latency: o_valid 1 cycle after the completing sample (sink idle) or after i_sink_done (from PEND).
// Backpressure: o_ready drops while a finished frame waits for a busy sink; samples then are dropped with o_overflow.
// Ports: i_clk/i_rst (sync, active-high); i_data/i_valid sample in; i_sink_done end of
//        downstream scan; o_data packed frame (element k at [k*inputWidth +: inputWidth]);
//        o_valid 1-cycle frame strobe; o_ready registered accept; o_overflow dropped-sample pulse.
// Optional: LAYER_PACKER_SOF_EN adds i_sof (restart at slot 0) and o_sync_err (misaligned SOF pulse).
module layer_packer
  import cnn_pkg::*;
#(
  parameter int numInput   = 10,
  parameter int inputWidth = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [inputWidth-1:0]          i_data,
  input  logic                           i_valid,
  input  logic                           i_sink_done,
`ifdef LAYER_PACKER_SOF_EN
  input  logic                           i_sof,
  output logic                           o_sync_err,
`endif
  output logic [numInput*inputWidth-1:0] o_data,
  output logic                           o_valid,
  output logic                           o_ready,
  output logic                           o_overflow
);

  localparam int IW = idx_width(numInput);
  localparam int FW = numInput * inputWidth;

  state_t          state_q;
  logic [FW-1:0]   buf_q;
  logic [FW-1:0]   frame_d;
  logic [FW-1:0]   o_data_q;
  logic            o_valid_q;
  logic            o_ready_q;
  logic            o_overflow_q;
  logic            busy_q;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   wr_slot;
  logic            accept;
  logic            sof;
  logic            resync;
  logic            last;
  logic            sink_free;
`ifdef LAYER_PACKER_SOF_EN
  logic            sync_err_q;
`endif

  assign accept = i_valid && (state_q == FILL);
`ifdef LAYER_PACKER_SOF_EN
  assign sof = accept && i_sof;
`else
  assign sof = 1'b0;
`endif
  // A start-of-frame that does not land on slot 0 means the partial frame is garbage.
  assign resync    = sof && (idx != '0);
  assign last      = accept && !sof && (idx == IW'(numInput - 1));
  // A done arriving in the completion cycle frees the sink for this frame.
  assign sink_free = !busy_q || i_sink_done;
  assign wr_slot   = sof ? '0 : idx;

  // Assembly buffer with the current sample merged in, so the completing
  // sample reaches o_data in the same edge that stores it.
  always_comb begin
    frame_d = resync ? '0 : buf_q;
    for (int k = 0; k < numInput; k++) begin
      if (wr_slot == IW'(k)) begin
        frame_d[k*inputWidth +: inputWidth] = i_data;
      end
    end
  end

  index_counter #(
    .N (numInput),
    .W (IW)
  ) u_idx (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_en    (accept),
    .i_load1 (sof),
    .o_idx   (idx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= FILL;
      buf_q        <= '0;
      o_data_q     <= '0;
      o_valid_q    <= 1'b0;
      o_ready_q    <= 1'b1;
      o_overflow_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef LAYER_PACKER_SOF_EN
      sync_err_q   <= 1'b0;
`endif
    end else begin
      o_valid_q    <= 1'b0;
      o_overflow_q <= 1'b0;
`ifdef LAYER_PACKER_SOF_EN
      sync_err_q   <= 1'b0;
`endif
      if (i_sink_done) begin
        busy_q <= 1'b0;
      end
      case (state_q)
        FILL: begin
          if (accept) begin
            buf_q <= frame_d;
`ifdef LAYER_PACKER_SOF_EN
            sync_err_q <= resync;
`endif
            if (last) begin
              if (sink_free) begin
                o_data_q  <= frame_d;
                o_valid_q <= 1'b1;
                busy_q    <= 1'b1;
              end else begin
                state_q   <= PEND;
                o_ready_q <= 1'b0;
              end
            end
          end
        end
        PEND: begin
          o_overflow_q <= i_valid;
          if (i_sink_done) begin
            o_data_q  <= buf_q;
            o_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            o_ready_q <= 1'b1;
            state_q   <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign o_data     = o_data_q;
  assign o_valid    = o_valid_q;
  assign o_ready    = o_ready_q;
  assign o_overflow = o_overflow_q;
`ifdef LAYER_PACKER_SOF_EN
  assign o_sync_err = sync_err_q;
`endif

endmodule
